// File: rtl/nn_dense_layer_sequencer.sv
// Dense (fully-connected) layer sequencer for fixed-point MNIST inference.
// Streams bias + weights per neuron from an Avalon-MM read master, multiplies
// each weight by the matching activation from on-chip RAM, accumulates, then
// writes the scaled/saturated (optionally ReLU'd) result and tracks the argmax.
module nn_dense_layer_sequencer #(
    parameter int DATA_W = 16,
    parameter int FRAC   = 8,
    parameter int ACC_W  = 40,
    parameter int ADDR_W = 25,
    parameter int N_MAX  = 784
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset,
    input  logic                     start,
    input  logic [9:0]               cfg_n_in,
    input  logic [9:0]               cfg_n_out,
    input  logic [ADDR_W-1:0]        cfg_w_base,
    input  logic                     cfg_relu,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [ADDR_W-1:0]        w_address,
    output logic                     w_read,
    input  logic                     w_waitrequest,
    input  logic signed [DATA_W-1:0] w_readdata,
    input  logic                     w_readdatavalid,
    output logic [9:0]               act_raddr,
    input  logic signed [DATA_W-1:0] act_rdata,
    output logic                     out_we,
    output logic [9:0]               out_waddr,
    output logic signed [DATA_W-1:0] out_wdata,
    output logic [9:0]               argmax_idx,
    output logic signed [DATA_W-1:0] argmax_val
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_BIAS_REQ,
        S_BIAS_WAIT,
        S_W_REQ,
        S_W_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [9:0] N_MAX_L = 10'(N_MAX);

    // Saturation bounds expressed at accumulator width for signed compares.
    localparam logic signed [ACC_W-1:0] SAT_HI =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Drop the fractional bits of the product scale and clamp to DATA_W.
    function automatic logic signed [DATA_W-1:0] sat_scale(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] r;
        r = a >>> FRAC;
        if (r > SAT_HI)
            sat_scale = SAT_HI[DATA_W-1:0];
        else if (r < SAT_LO)
            sat_scale = SAT_LO[DATA_W-1:0];
        else
            sat_scale = r[DATA_W-1:0];
    endfunction

    // Optional ReLU: negative values become zero when enabled.
    function automatic logic signed [DATA_W-1:0] relu_clamp(input logic signed [DATA_W-1:0] x,
                                                            input logic en);
        relu_clamp = (en && x[DATA_W-1]) ? '0 : x;
    endfunction

    state_t state, state_nxt;

    logic [9:0]               n_in_r;
    logic [9:0]               n_out_r;
    logic                     relu_r;
    logic [ADDR_W-1:0]        addr_r;
    logic [9:0]               i_cnt;
    logic [9:0]               j_cnt;
    logic signed [ACC_W-1:0]  acc;

    logic                     cfg_bad;
    logic                     last_in;
    logic                     last_out;
    logic                     accept;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [DATA_W-1:0] result;

    assign cfg_bad  = (n_in_r == 10'd0) || (n_out_r == 10'd0) ||
                      (n_in_r > N_MAX_L) || (n_out_r > N_MAX_L);
    assign last_in  = (i_cnt == n_in_r - 10'd1);
    assign last_out = (j_cnt == n_out_r - 10'd1);
    assign accept   = w_read && !w_waitrequest;

    // Full-precision product and sign-extended operands at accumulator width.
    assign prod     = w_readdata * act_rdata;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_W){w_readdata[DATA_W-1]}}, w_readdata};
    assign result   = relu_clamp(sat_scale(acc), relu_r);

    assign w_address = addr_r;
    assign act_raddr = i_cnt;
    assign out_waddr = j_cnt;
    assign out_wdata = result;

    // State register.
    always_ff @(posedge clk_clk) begin
        if (reset_reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; each read phase waits for acceptance, then for its data.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start) state_nxt = S_CHECK;
            S_CHECK:     state_nxt = cfg_bad ? S_DONE : S_BIAS_REQ;
            S_BIAS_REQ:  if (!w_waitrequest) state_nxt = S_BIAS_WAIT;
            S_BIAS_WAIT: if (w_readdatavalid) state_nxt = S_W_REQ;
            S_W_REQ:     if (!w_waitrequest) state_nxt = S_W_WAIT;
            S_W_WAIT:    if (w_readdatavalid) state_nxt = last_in ? S_WRITE : S_W_REQ;
            S_WRITE:     state_nxt = last_out ? S_DONE : S_BIAS_REQ;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        busy   = (state != S_IDLE);
        done   = (state == S_DONE);
        w_read = (state == S_BIAS_REQ) || (state == S_W_REQ);
        out_we = (state == S_WRITE);
    end

    // Control: latched config, running word address, loop counters, sticky error.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            n_in_r  <= '0;
            n_out_r <= '0;
            relu_r  <= 1'b0;
            addr_r  <= '0;
            i_cnt   <= '0;
            j_cnt   <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_in_r  <= cfg_n_in;
                        n_out_r <= cfg_n_out;
                        relu_r  <= cfg_relu;
                        addr_r  <= cfg_w_base;
                        i_cnt   <= '0;
                        j_cnt   <= '0;
                        err     <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (cfg_bad)
                        err <= 1'b1;
                end
                // Rows are contiguous, so one incrementing pointer walks every neuron.
                S_BIAS_REQ, S_W_REQ: begin
                    if (accept)
                        addr_r <= addr_r + 1'b1;
                end
                S_W_WAIT: begin
                    if (w_readdatavalid)
                        i_cnt <= i_cnt + 10'd1;
                end
                S_WRITE: begin
                    i_cnt <= '0;
                    j_cnt <= j_cnt + 10'd1;
                end
                default: ;
            endcase
        end
    end

    // Datapath: bias preload, multiply-accumulate, argmax tracking on each write.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            acc        <= '0;
            argmax_idx <= '0;
            argmax_val <= '0;
        end else begin
            case (state)
                S_BIAS_WAIT: begin
                    if (w_readdatavalid)
                        acc <= bias_ext <<< FRAC;
                end
                S_W_WAIT: begin
                    if (w_readdatavalid)
                        acc <= acc + prod_ext;
                end
                S_WRITE: begin
                    // Strictly-greater update keeps the lowest index on ties.
                    if ((j_cnt == 10'd0) || (result > argmax_val)) begin
                        argmax_idx <= j_cnt;
                        argmax_val <= result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_dense_layer_sequencer.sv
// Bench for nn_dense_layer_sequencer: Avalon slave with optional random stalls
// and return gaps, synchronous activation RAM, output RAM capture, and a plain
// arithmetic reference for each neuron's output and the layer argmax.
module tb_nn_dense_layer_sequencer;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_reset, start, cfg_relu;
  logic [9:0]        cfg_n_in, cfg_n_out;
  logic [ADDR_W-1:0] cfg_w_base;
  logic              busy, done, err;
  logic [ADDR_W-1:0] w_address;
  logic              w_read, w_waitrequest, w_readdatavalid;
  logic [DATA_W-1:0] w_readdata;
  logic [9:0]        act_raddr;
  logic [DATA_W-1:0] act_rdata;
  logic              out_we;
  logic [9:0]        out_waddr;
  logic [DATA_W-1:0] out_wdata;
  logic [9:0]        argmax_idx;
  logic [DATA_W-1:0] argmax_val;

  nn_dense_layer_sequencer dut (
    .clk_clk(clk), .reset_reset(reset_reset), .start(start),
    .cfg_n_in(cfg_n_in), .cfg_n_out(cfg_n_out), .cfg_w_base(cfg_w_base), .cfg_relu(cfg_relu),
    .busy(busy), .done(done), .err(err),
    .w_address(w_address), .w_read(w_read), .w_waitrequest(w_waitrequest),
    .w_readdata(w_readdata), .w_readdatavalid(w_readdatavalid),
    .act_raddr(act_raddr), .act_rdata(act_rdata),
    .out_we(out_we), .out_waddr(out_waddr), .out_wdata(out_wdata),
    .argmax_idx(argmax_idx), .argmax_val(argmax_val)
  );

  logic [15:0] w_mem   [0:4095];
  logic [15:0] act_mem [0:1023];
  logic [15:0] out_mem [0:1023];

  int n_checks = 0;
  int n_errors = 0;

  bit   rand_mode = 1'b0;
  int   force_gap = -1;
  int   ret_cd = 0, ret_addr = 0, outstanding = 0;
  int   n_viol = 0, n_writes = 0, n_done = 0, n_rd_cyc = 0, n_acc = 0;
  bit   prev_stall = 1'b0, prev_rst = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Synchronous activation RAM: one-cycle read latency.
  always @(posedge clk) act_rdata <= act_mem[act_raddr];

  // Avalon slave, output RAM capture and protocol monitors, all at the falling edge.
  always @(negedge clk) begin
    bit wr;
    int gap;
    if (out_we) begin
      out_mem[out_waddr] = out_wdata;
      n_writes++;
    end
    if (done) n_done++;
    if (w_read) n_rd_cyc++;
    if (prev_stall && !prev_rst && (!w_read || w_address != prev_addr)) n_viol++;
    w_readdatavalid = 1'b0;
    w_readdata = 16'($urandom);
    if (ret_cd > 0) begin
      ret_cd--;
      if (ret_cd == 0) begin
        w_readdatavalid = 1'b1;
        w_readdata = w_mem[ret_addr];
        outstanding--;
      end
    end
    wr = rand_mode && ($urandom_range(0, 2) == 0);
    if (w_read && !wr && !reset_reset) begin
      if (outstanding != 0) n_viol++;
      outstanding++;
      n_acc++;
      ret_addr = int'(w_address);
      gap = (force_gap >= 0) ? force_gap : (rand_mode ? int'($urandom_range(0, 5)) : 0);
      ret_cd = 1 + gap;
    end
    w_waitrequest = wr;
    prev_stall = w_read && wr;
    prev_addr = w_address;
    prev_rst = reset_reset;
  end

  function automatic logic [15:0] ref_out(int j, int n_in, int base, bit relu);
    longint acc, r;
    int row;
    row = base + j * (n_in + 1);
    acc = longint'($signed(w_mem[row])) * 256;
    for (int i = 0; i < n_in; i++)
      acc += longint'($signed(w_mem[row + 1 + i])) * longint'($signed(act_mem[i]));
    r = acc >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return 16'(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Starts a layer; cyc is the index of the first rising edge (start edge = 0)
  // at which done is sampled high. err_s is err just after the start edge.
  task automatic run_layer(input string tag, input int n_in, input int n_out, input int base,
                           input bit relu, input bit rnd, output int cyc, output logic err_s);
    rand_mode = rnd;
    n_writes = 0;
    n_done = 0;
    n_acc = 0;
    for (int k = 0; k < 1024; k++) out_mem[k] = 16'hDEAD;
    tick();
    cfg_n_in = 10'(n_in);
    cfg_n_out = 10'(n_out);
    cfg_w_base = ADDR_W'(base);
    cfg_relu = relu;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    err_s = 1'bx;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) err_s = err;
    end while (!done && cyc < 20000);
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_busy_in_done"}, busy, 1);
    tick();
    tick();
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_pulses"}, n_done, 1);
  endtask

  task automatic verify_layer(input string tag, input int n_in, input int n_out,
                              input int base, input bit relu);
    int best_i;
    logic [15:0] best_v, v;
    best_i = 0;
    best_v = '0;
    for (int j = 0; j < n_out; j++) begin
      v = ref_out(j, n_in, base, relu);
      check($sformatf("%s_out%0d", tag, j), out_mem[j], v);
      if (j == 0 || $signed(v) > $signed(best_v)) begin
        best_i = j;
        best_v = v;
      end
    end
    check({tag, "_argmax_idx"}, argmax_idx, best_i);
    check({tag, "_argmax_val"}, argmax_val, best_v);
    check({tag, "_writes"}, n_writes, n_out);
    check({tag, "_reads"}, n_acc, n_out * (n_in + 1));
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc, rn_in, rn_out, rbase, rd0;
    logic es;
    bit rrelu;

    for (int k = 0; k < 4096; k++) w_mem[k] = '0;
    for (int k = 0; k < 1024; k++) act_mem[k] = '0;
    w_waitrequest = 1'b0;
    w_readdatavalid = 1'b0;
    w_readdata = '0;
    reset_reset = 1'b1;
    start = 1'b0;
    cfg_n_in = '0;
    cfg_n_out = '0;
    cfg_w_base = '0;
    cfg_relu = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_w_read", w_read, 0);
    check("rst_w_address", w_address, 0);
    check("rst_out_we", out_we, 0);
    check("rst_out_wdata", out_wdata, 0);
    check("rst_act_raddr", act_raddr, 0);
    check("rst_argmax", {argmax_idx, argmax_val}, 0);
    reset_reset = 1'b0;
    tick();

    // Basic two-neuron layer, no ReLU, zero-wait memory.
    w_mem[16] = 16'h0100; w_mem[17] = 16'h0200; w_mem[18] = 16'h0080;
    w_mem[19] = 16'hFF00; w_mem[20] = 16'h0100; w_mem[21] = 16'hFF00;
    act_mem[0] = 16'h0100; act_mem[1] = 16'h0400;
    run_layer("t1", 2, 2, 16, 1'b0, 1'b0, cyc, es);
    check("t1_latency", cyc, 16);
    verify_layer("t1", 2, 2, 16, 1'b0);
    check("t1_out0_const", out_mem[0], 16'h0500);
    check("t1_out1_const", out_mem[1], 16'hFC00);
    check("t1_argmax_const", {argmax_idx, argmax_val}, {10'd0, 16'h0500});

    // Same layer with ReLU.
    run_layer("t2", 2, 2, 16, 1'b1, 1'b0, cyc, es);
    verify_layer("t2", 2, 2, 16, 1'b1);
    check("t2_out1_const", out_mem[1], 16'h0000);

    // Saturation at both ends.
    w_mem[32] = 16'h7FFF; w_mem[33] = 16'h7FFF;
    act_mem[0] = 16'h7FFF;
    run_layer("t3a", 1, 1, 32, 1'b0, 1'b0, cyc, es);
    check("t3a_latency", cyc, 7);
    verify_layer("t3a", 1, 1, 32, 1'b0);
    check("t3a_const", out_mem[0], 16'h7FFF);
    w_mem[34] = 16'h8000; w_mem[35] = 16'h7FFF;
    act_mem[0] = 16'h8000;
    run_layer("t3b", 1, 1, 34, 1'b0, 1'b0, cyc, es);
    verify_layer("t3b", 1, 1, 34, 1'b0);
    check("t3b_const", out_mem[0], 16'h8000);

    // Random layers: zero-wait with exact latency, then with stalls and return gaps.
    for (int it = 0; it < 4; it++) begin
      rn_in = $urandom_range(1, 8);
      rn_out = $urandom_range(1, 6);
      rbase = 1000 + $urandom_range(0, 500);
      rrelu = 1'($urandom_range(0, 1));
      for (int k = 0; k < rn_in; k++) act_mem[k] = 16'($urandom);
      for (int k = 0; k < rn_out * (rn_in + 1); k++) w_mem[rbase + k] = 16'($urandom);
      run_layer($sformatf("t4z%0d", it), rn_in, rn_out, rbase, rrelu, 1'b0, cyc, es);
      check($sformatf("t4z%0d_latency", it), cyc, 2 + rn_out * (2 * rn_in + 3));
      verify_layer($sformatf("t4z%0d", it), rn_in, rn_out, rbase, rrelu);
      run_layer($sformatf("t4r%0d", it), rn_in, rn_out, rbase, rrelu, 1'b1, cyc, es);
      verify_layer($sformatf("t4r%0d", it), rn_in, rn_out, rbase, rrelu);
    end
    rand_mode = 1'b0;

    // Bad configurations: error flagged, quick done, no memory traffic.
    rd0 = n_rd_cyc;
    run_layer("t5a", 0, 2, 16, 1'b0, 1'b0, cyc, es);
    check("t5a_err", err, 1);
    check("t5a_fast_done", cyc <= 3, 1);
    check("t5a_no_read", n_rd_cyc - rd0, 0);
    check("t5a_no_write", n_writes, 0);
    rd0 = n_rd_cyc;
    run_layer("t5b", 2, 785, 16, 1'b0, 1'b0, cyc, es);
    check("t5b_err", err, 1);
    check("t5b_no_read", n_rd_cyc - rd0, 0);
    repeat (3) tick();
    check("t5_err_sticky", err, 1);
    act_mem[0] = 16'h0100; act_mem[1] = 16'h0400;
    run_layer("t5c", 2, 2, 16, 1'b0, 1'b0, cyc, es);
    check("t5c_err_cleared_at_start", es, 0);
    verify_layer("t5c", 2, 2, 16, 1'b0);

    // Reset while waiting on a weight, with its data returning after the reset.
    force_gap = 5;
    rand_mode = 1'b0;
    n_writes = 0;
    n_done = 0;
    n_acc = 0;
    tick();
    cfg_n_in = 10'd2; cfg_n_out = 10'd2; cfg_w_base = ADDR_W'(16); cfg_relu = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 100 && n_acc < 2; k++) tick();
    check("t6_weight_req_reached", n_acc, 2);
    reset_reset = 1'b1;
    tick();
    reset_reset = 1'b0;
    repeat (10) tick();
    force_gap = -1;
    check("t6_no_write", n_writes, 0);
    check("t6_no_done", n_done, 0);
    check("t6_idle", busy, 0);
    check("t6_err", err, 0);
    check("t6_stale_drained", outstanding, 0);

    // Fresh run after the reset: tied outputs keep the lowest index.
    w_mem[200] = 16'h0300; w_mem[201] = 16'h0000;
    w_mem[202] = 16'h0300; w_mem[203] = 16'h0000;
    run_layer("t6b", 1, 2, 200, 1'b0, 1'b0, cyc, es);
    check("t6b_latency", cyc, 12);
    verify_layer("t6b", 1, 2, 200, 1'b0);
    check("t6b_tie_const", {argmax_idx, argmax_val}, {10'd0, 16'h0300});

    check("protocol_violations", n_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
